// File: rtl/uart_ram_loader.sv
// uart_ram_loader: receives 8N1 bytes on rx and writes them into consecutive
// RAM addresses, holding the CPU halted until the whole RAM is filled.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
// dbg_state_o exposes the FSM state for observation.
//
// Output behaviour:
//   ram_write is high for exactly the one cycle the FSM spends in WRITE,
//   and ram_addr/ram_data are valid in that cycle. ram_addr and ram_data
//   keep their last values in every other cycle.
module uart_ram_loader #(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_data,
    output logic                  ram_write,
    output logic                  cpu_halt,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_error,
    output logic                  checksum_error,
    output logic [2:0]            dbg_state_o
);

    localparam int BIT_TICKS  = CLK_FREQ / BAUD;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CNT_W      = $clog2(BIT_TICKS + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        START      = 3'd2,
        DATA       = 3'd3,
        STOP       = 3'd4,
        WRITE      = 3'd5,
        FINISH     = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;
    logic                  cerr_q, cerr_d;
    logic                  rx_meta_q, rx_sync_q, rx_prev_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
    logic                  ck_phase_q, ck_phase_d;
`endif

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Next-state logic: bit timing, byte assembly, write sequencing, status.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        index_d = index_q;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ferr_d  = ferr_q;
        cerr_d  = cerr_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        ck_phase_d = ck_phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_START;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    ferr_d  = 1'b0;
                    cerr_d  = 1'b0;
                    index_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = 8'h00;
                    ck_phase_d = 1'b0;
`endif
                end
            end
            WAIT_START: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Mid-bit check of the start bit rejects short low glitches.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = rx_sync_q ? WAIT_START : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!rx_sync_q) begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_START;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        if (ck_phase_q) begin
                            cerr_d  = (shift_q != sum_q);
                            state_d = FINISH;
                        end else begin
                            addr_d  = index_q;
                            data_d  = shift_q;
                            state_d = WRITE;
                        end
`else
                        addr_d  = index_q;
                        data_d  = shift_q;
                        state_d = WRITE;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WRITE: begin
                index_d = index_q + IDX_ONE;
`ifdef LOADER_CHECKSUM_EN
                sum_d = sum_q + data_q;
                if (index_q == '1) ck_phase_d = 1'b1;
                state_d = WAIT_START;
`else
                state_d = (index_q == '1) ? FINISH : WAIT_START;
`endif
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            index_q <= '0;
            addr_q  <= '0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            cerr_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= 8'h00;
            ck_phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            cerr_q  <= cerr_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            ck_phase_q <= ck_phase_d;
`endif
        end
    end

    assign ram_write      = (state_q == WRITE);
    assign ram_addr       = addr_q;
    assign ram_data       = data_q;
    assign busy           = busy_q;
    assign cpu_halt       = busy_q;
    assign done           = done_q;
    assign frame_error    = ferr_q;
    assign checksum_error = cerr_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Testbench for uart_ram_loader with CLK_FREQ=16, BAUD=1 (16 clocks per bit).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_ram_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       start = 1'b0;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_write, cpu_halt, busy, done, frame_error, checksum_error;
    logic [2:0] dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int write_count = 0;

    // Expected RAM writes as {addr, data}, in order.
    logic [11:0] exp_q[$];
    logic [3:0]  m_index = 4'd0;
    logic [7:0]  m_sum = 8'h00;
    logic [3:0]  hold_addr = 4'd0;
    logic [7:0]  hold_data = 8'h00;
    logic        prev_write = 1'b0;
    logic        rst_smp = 1'b0;
    logic        mon_en = 1'b0;

    uart_ram_loader #(.CLK_FREQ(16), .BAUD(1), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .rx(rx), .start(start),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_write(ram_write),
        .cpu_halt(cpu_halt), .busy(busy), .done(done),
        .frame_error(frame_error), .checksum_error(checksum_error),
        .dbg_state_o(dbg_state)
    );

    // Clock and reset-sample block.
    always #5 clk = ~clk;
    always @(posedge clk) rst_smp = rst;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks.
    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
        m_index = 4'd0;
        m_sum = 8'h00;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(16);
        end
        rx = stop_bit;
        tick(16);
        rx = 1'b1;
        tick(4);
    endtask

    // Model: a good frame during a load lands at the next address.
    task automatic expect_write(input logic [7:0] b);
        exp_q.push_back({m_index, b});
        m_sum = m_sum + b;
        m_index = m_index + 4'd1;
    endtask

    task automatic new_load();
        pulse_start();
        m_index = 4'd0;
        m_sum = 8'h00;
    endtask

    // Scoreboard / monitor: checks every cycle after the first reset.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_smp) begin
                hold_addr = 4'd0;
                hold_data = 8'h00;
            end
            check("halt_eq_busy", {31'd0, cpu_halt}, {31'd0, busy});
            if (ram_write === 1'b1) begin
                check("write_single_cycle", {31'd0, prev_write}, 32'd0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: addr %0h data %0h with no write expected", ram_addr, ram_data);
                end else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    check("write_addr_data", {20'd0, ram_addr, ram_data}, {20'd0, e});
                    hold_addr = e[11:8];
                    hold_data = e[7:0];
                    write_count++;
                end
            end else begin
                check("addr_data_hold", {20'd0, ram_addr, ram_data}, {20'd0, hold_addr, hold_data});
            end
            prev_write = ram_write;
        end
    end

    task automatic check_drained(input string name);
        check(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        tick(1);
        // Reset held two cycles: everything cleared.
        do_reset(2);
        mon_en = 1'b1;
        check("rst_ram_write", {31'd0, ram_write}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cpu_halt", {31'd0, cpu_halt}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ferr", {31'd0, frame_error}, 32'd0);
        check("rst_cerr", {31'd0, checksum_error}, 32'd0);
        check("rst_addr", {28'd0, ram_addr}, 32'd0);
        check("rst_data", {24'd0, ram_data}, 32'd0);
        check("rst_state_idle", {29'd0, dbg_state}, 32'd0);

        // Single byte 0xA5 lands at address 0 while halted.
        new_load();
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_halt", {31'd0, cpu_halt}, 32'd1);
        expect_write(8'hA5);
        send_frame(8'hA5, 1'b1);
        check_drained("a5_written");
        check("a5_count", write_count, 32'd1);
        check("a5_last_data", {24'd0, ram_data}, 32'hA5);
        check("a5_still_busy", {31'd0, busy}, 32'd1);
        do_reset(1);
        check("a5_rst_busy", {31'd0, busy}, 32'd0);

        // Full load 0x00..0x0F fills addresses 0..15.
        new_load();
        for (int i = 0; i < 16; i++) begin
            expect_write(8'(i));
            send_frame(8'(i), 1'b1);
            if (i == 7) pulse_start();
        end
        check_drained("full_written");
        check("full_count", write_count, 32'd17);
        check("full_last_addr", {28'd0, ram_addr}, 32'hF);
`ifdef LOADER_CHECKSUM_EN
        check("ck_pending_busy", {31'd0, busy}, 32'd1);
        send_frame(8'h78, 1'b1);
        check("ck_good_cerr", {31'd0, checksum_error}, {31'd0, (m_sum != 8'h78)});
        check("ck_good_cerr_lit", {31'd0, checksum_error}, 32'd0);
`else
        check("full_cerr_tied", {31'd0, checksum_error}, 32'd0);
`endif
        check("full_done", {31'd0, done}, 32'd1);
        check("full_busy", {31'd0, busy}, 32'd0);
        check("full_halt", {31'd0, cpu_halt}, 32'd0);
        check("full_state_idle", {29'd0, dbg_state}, 32'd0);
        tick(20);
        check("done_sticky", {31'd0, done}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
        new_load();
        for (int i = 0; i < 16; i++) begin
            expect_write(8'(i));
            send_frame(8'(i), 1'b1);
        end
        check_drained("full2_written");
        send_frame(8'h77, 1'b1);
        check("ck_bad_cerr", {31'd0, checksum_error}, 32'd1);
        check("ck_bad_done", {31'd0, done}, 32'd1);
`endif

        // Frame error, glitch rejection, ignored start, reset mid-byte.
        new_load();
        check("restart_done_clr", {31'd0, done}, 32'd0);
        check("restart_ferr_clr", {31'd0, frame_error}, 32'd0);
        send_frame(8'h3C, 1'b0);
        check_drained("ferr_no_write");
        check("ferr_set", {31'd0, frame_error}, 32'd1);
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(20);
        check("glitch_state", {29'd0, dbg_state}, 32'd1);
        check_drained("glitch_no_write");
        expect_write(8'h11);
        send_frame(8'h11, 1'b1);
        check_drained("after_ferr_written");
        check("after_ferr_addr", {28'd0, ram_addr}, 32'h0);
        check("ferr_sticky", {31'd0, frame_error}, 32'd1);
        pulse_start();
        expect_write(8'h22);
        send_frame(8'h22, 1'b1);
        expect_write(8'h33);
        send_frame(8'h33, 1'b1);
        expect_write(8'h44);
        send_frame(8'h44, 1'b1);
        check_drained("mid_written");
        check("mid_addr", {28'd0, ram_addr}, 32'h3);
        // Sixth frame: reset lands during data bit 4.
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            tick(16);
        end
        rx = 1'b0;
        tick(8);
        do_reset(1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_halt", {31'd0, cpu_halt}, 32'd0);
        check("midrst_ferr", {31'd0, frame_error}, 32'd0);
        check("midrst_addr", {28'd0, ram_addr}, 32'd0);
        check("midrst_state", {29'd0, dbg_state}, 32'd0);
        tick(40);
        rx = 1'b1;
        tick(40);
        check_drained("midrst_no_write");
        new_load();
        expect_write(8'h42);
        send_frame(8'h42, 1'b1);
        check_drained("post_rst_written");
        check("post_rst_addr", {28'd0, ram_addr}, 32'h0);
        check("post_rst_data", {24'd0, ram_data}, 32'h42);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_ram_loader.md
UART_RAM_LOADER -- requirements
Module: uart_ram_loader

Interface
REQ-001 Parameter CLK_FREQ, default 27000000, system clock frequency in Hz SHALL be provided.
REQ-002 Parameter BAUD, default 115200, serial bit rate SHALL be provided.
REQ-003 Parameter ADDR_WIDTH, default 4, RAM address width, depth 2^ADDR_WIDTH SHALL be provided.
REQ-004 Port clk  input  1  system clock; all logic SHALL be on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset SHALL be provided.
REQ-006 Port rx  input  1  asynchronous UART line, idle high, 8N1, LSB first SHALL be provided.
REQ-007 Port start  input  1  single-cycle request to begin a load SHALL be provided.
REQ-008 Port ram_addr  output  ADDR_WIDTH  write address to RAM SHALL be provided.
REQ-009 Port ram_data  output  8  write data to RAM SHALL be provided.
REQ-010 Port ram_write  output  1  one-cycle RAM write strobe SHALL be provided.
REQ-011 Port cpu_halt  output  1  holds CPU clock halted while loading SHALL be provided.
REQ-012 Port busy  output  1  load in progress SHALL be provided.
REQ-013 Port done  output  1  last load completed SHALL be provided.
REQ-014 Port frame_error  output  1  sticky; a byte was dropped for a bad stop bit SHALL be provided.
REQ-015 Port checksum_error  output  1  trailing checksum mismatch SHALL be provided.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized value.
REQ-017 BIT_TICKS SHALL equal CLK_FREQ/BAUD (integer division); HALF_TICKS SHALL equal BIT_TICKS/2.
REQ-018 FSM states SHALL be IDLE, WAIT_START, START, DATA, STOP, WRITE, FINISH.
REQ-019 IDLE -> WAIT_START on start=1: busy=1, cpu_halt=1, done=0, frame_error=0, checksum_error=0, index=0.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 WAIT_START -> START on a synchronized falling edge of rx; START SHALL count HALF_TICKS then sample rx.
REQ-022 At the START sample, rx=1 SHALL be treated as a glitch and return to WAIT_START with no other effect; rx=0 SHALL go to DATA.
REQ-023 DATA SHALL sample 8 bits at BIT_TICKS intervals, LSB first, into a shift register.
REQ-024 STOP SHALL sample after BIT_TICKS more: rx=1 -> WRITE; rx=0 -> frame_error=1, byte discarded, index unchanged, WAIT_START.
REQ-025 WRITE SHALL last exactly one cycle: ram_write=1, ram_addr=index, ram_data=received byte; index SHALL increment after it.
REQ-026 ram_write SHALL be 0 in every other cycle; ram_addr and ram_data SHALL hold their last values.
REQ-027 After the WRITE of index 2^ADDR_WIDTH-1, the FSM SHALL go to FINISH; index SHALL NOT wrap into a further write.
REQ-028 FINISH SHALL last one cycle, then IDLE with busy=0, cpu_halt=0, done=1; done SHALL stay high until the next accepted start or rst.
REQ-029 cpu_halt SHALL equal busy in every cycle.

Reset
REQ-030 rst=1 SHALL force IDLE, index=0, shift register=0, ram_addr=0, ram_data=0, and all 1-bit outputs to 0 on the next edge, including mid-byte.
REQ-031 A partially received byte SHALL NOT be written after reset.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN SHALL select checksum behaviour.
REQ-033 With LOADER_CHECKSUM_EN defined, after the last data WRITE the loader SHALL receive one additional byte (same framing rules, no ram_write).
REQ-034 The loader SHALL compare that byte to the mod-256 sum of all written data bytes and set checksum_error=1 on mismatch before FINISH.
REQ-035 Without LOADER_CHECKSUM_EN, FINISH SHALL follow the last data WRITE directly and checksum_error SHALL be tied 0.

Verification (CLK_FREQ=16, BAUD=1, BIT_TICKS=16)
REQ-036 rst held 2 cycles -> all outputs 0, ram_addr=0.
REQ-037 start, then send 0xA5 -> exactly one ram_write pulse with ram_addr=0, ram_data=0xA5; busy=cpu_halt=1.
REQ-038 start, then send 0x00..0x0F -> 16 writes to addr 0..15, then done=1, busy=0, cpu_halt=0. With LOADER_CHECKSUM_EN, a trailing 0x78 -> checksum_error=0; a trailing 0x77 -> checksum_error=1.
REQ-039 send 0x3C with stop bit low -> no write, frame_error=1; next byte 0x11 -> written at the same address.
REQ-040 drive rx low for 3 cycles in WAIT_START -> no write, FSM back in WAIT_START, index unchanged.
REQ-041 assert rst during bit 4 of the 6th byte -> no write, busy=0 next cycle; new start + 0x42 -> write at addr 0.
